// File: rtl/spi_config_regs.sv
// spi_config_regs: SPI-addressed FM transmitter config registers with shadow/active commit
// Ports: spi_clk, rst (async, active-high), spi_csn (active-low frame), spi_mosi, spi_miso  - SPI mode 0 slave
//        usb_i2sn_pin, audio_chan_sel_pin, i2s_ws_align_pin, dith_disable_pin           - pin-level config
//        acc_inc, df_inc_coef, df_inc_fact, dac_ena, dith_fact                         - active NCO/FM/DAC config
//        usb_i2sn, audio_chan_sel, i2s_ws_align                                        - audio flags after pin override
module spi_config_regs #(
    parameter int N = 18,
    parameter int K = 4,
    parameter int L = 2,
    parameter int D = 5,
    parameter logic [7:0] ID = 8'hA5
) (
    input  logic         spi_clk,
    input  logic         rst,
    input  logic         spi_csn,
    input  logic         spi_mosi,
    output logic         spi_miso,
    input  logic         usb_i2sn_pin,
    input  logic         audio_chan_sel_pin,
    input  logic         i2s_ws_align_pin,
    input  logic         dith_disable_pin,
    output logic [N-1:0] acc_inc,
    output logic [K-1:0] df_inc_coef,
    output logic [L-1:0] df_inc_fact,
    output logic [D-1:0] dac_ena,
    output logic [2:0]   dith_fact,
    output logic         usb_i2sn,
    output logic         audio_chan_sel,
    output logic         i2s_ws_align
);
    localparam logic [23:0] ACC_MASK = 24'((64'd1 << N) - 64'd1);
    localparam logic [7:0]  CF_MASK  = 8'((16'd1 << (K + L)) - 16'd1);
    localparam logic [7:0]  DAC_MASK = 8'((16'd1 << D) - 16'd1);
    localparam logic [7:0]  COEF_RST = 8'((16'd1 << K) - 16'd1) & 8'd15;
    localparam logic [23:0] ACC_RST  = 24'h010000 & ACC_MASK;
    // Byte lanes 0..6 of the map; the lane mask keeps unimplemented bits at zero so they read back 0.
    localparam logic [6:0][7:0] MASK = {8'h0F, 8'h07, DAC_MASK, CF_MASK, ACC_MASK[23:16], 8'hFF, 8'hFF};
    localparam logic [6:0][7:0] RST  = {8'h00, 8'h02, DAC_MASK, COEF_RST, ACC_RST[23:16], ACC_RST[15:8], ACC_RST[7:0]};

    typedef enum logic {CMD, DATA} state_t;
    state_t state, state_n;
    logic frame_rst, is_rd, byte_end, wr_en, ovr;
    logic [2:0] bit_cnt;
    logic [6:0] sh, addr, rd_addr;
    logic [7:0] byte_in, rd_sr, rd_data;
    logic [6:0][7:0] shd, act;

    assign frame_rst = rst | spi_csn;
    assign byte_in   = {sh, spi_mosi};
    assign byte_end  = bit_cnt == 3'd7;
    assign wr_en     = state == DATA && !is_rd && byte_end;
    // The command byte reads the address it carries; each data byte prefetches the next address.
    assign rd_addr   = state == CMD ? byte_in[6:0] : addr + 7'd1;
    assign rd_data   = rd_addr < 7'd7 ? act[rd_addr[2:0]] : rd_addr == 7'd7 ? ID : 8'h00;

    always_comb begin
        state_n = state;
        if (state == CMD && byte_end) state_n = DATA;
    end

    always_ff @(posedge spi_clk or posedge frame_rst)
        if (frame_rst) begin
            state   <= CMD;
            bit_cnt <= 3'd0;
            sh      <= 7'd0;
            addr    <= 7'd0;
            is_rd   <= 1'b0;
            rd_sr   <= 8'd0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt + 3'd1;
            sh      <= byte_in[6:0];
            rd_sr   <= byte_end ? rd_data : {rd_sr[6:0], 1'b0};
            if (byte_end) addr <= state == CMD ? byte_in[6:0] : addr + 7'd1;
            if (byte_end && state == CMD) is_rd <= byte_in[7];
        end

    always_ff @(negedge spi_clk or posedge frame_rst)
        if (frame_rst) spi_miso <= 1'b0;
        else spi_miso <= state == DATA && is_rd && rd_sr[7];

    // Commit copies every shadow lane at once so downstream fields change on a single edge.
    always_ff @(posedge spi_clk or posedge rst)
        if (rst) begin
            shd <= RST;
            act <= RST;
        end else if (wr_en && addr < 7'd7) shd[addr[2:0]] <= byte_in & MASK[addr[2:0]];
        else if (wr_en && addr == 7'h7F && byte_in[0]) act <= shd;

    assign ovr            = act[6][3];
    assign acc_inc        = N'({act[2], act[1], act[0]});
    assign df_inc_coef    = act[3][K-1:0];
    assign df_inc_fact    = act[3][K+L-1:K];
    assign dac_ena        = act[4][D-1:0];
    assign dith_fact      = !ovr && dith_disable_pin ? 3'd0 : act[5][2:0];
    assign usb_i2sn       = ovr ? act[6][0] : usb_i2sn_pin;
    assign audio_chan_sel = ovr ? act[6][1] : audio_chan_sel_pin;
    assign i2s_ws_align   = ovr ? act[6][2] : i2s_ws_align_pin;
endmodule

// File: tb/tb_spi_config_regs.sv
// tb_spi_config_regs: randomized SPI frames checked against a field-level register model
module tb_spi_config_regs;
    localparam int N = 18;
    localparam int K = 4;
    localparam int L = 2;
    localparam int D = 5;
    localparam logic [7:0] ID = 8'hA5;

    logic spi_clk, rst, spi_csn, spi_mosi, spi_miso;
    logic usb_i2sn_pin, audio_chan_sel_pin, i2s_ws_align_pin, dith_disable_pin;
    logic [N-1:0] acc_inc;
    logic [K-1:0] df_inc_coef;
    logic [L-1:0] df_inc_fact;
    logic [D-1:0] dac_ena;
    logic [2:0] dith_fact;
    logic usb_i2sn, audio_chan_sel, i2s_ws_align;

    spi_config_regs #(.N(N), .K(K), .L(L), .D(D), .ID(ID)) dut (
        .spi_clk(spi_clk), .rst(rst), .spi_csn(spi_csn), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .usb_i2sn_pin(usb_i2sn_pin), .audio_chan_sel_pin(audio_chan_sel_pin),
        .i2s_ws_align_pin(i2s_ws_align_pin), .dith_disable_pin(dith_disable_pin),
        .acc_inc(acc_inc), .df_inc_coef(df_inc_coef), .df_inc_fact(df_inc_fact), .dac_ena(dac_ena),
        .dith_fact(dith_fact), .usb_i2sn(usb_i2sn), .audio_chan_sel(audio_chan_sel), .i2s_ws_align(i2s_ws_align)
    );

    initial spi_clk = 1'b0;
    always #5 spi_clk = ~spi_clk;

    typedef struct {int acc; int coef; int fact; int dac; int dith; int ovr; int ws; int chan; int usb;} regs_t;
    regs_t shd, act;
    int checks = 0;
    int errors = 0;
    logic [7:0] wdat [4];
    logic [7:0] exp1 [8] = '{8'h00, 8'h00, 8'h01, 8'h0F, 8'h1F, 8'h02, 8'h00, 8'hA5};
    logic [7:0] r;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        act.acc = 65536 % (1 << N);
        act.coef = 15 % (1 << K);
        act.fact = 0;
        act.dac = (1 << D) - 1;
        act.dith = 2;
        act.ovr = 0; act.ws = 0; act.chan = 0; act.usb = 0;
        shd = act;
    endfunction

    function automatic void model_write(input int a, input int b);
        case (a)
            0: shd.acc = ((shd.acc & 'hFFFF00) | b) % (1 << N);
            1: shd.acc = ((shd.acc & 'hFF00FF) | (b << 8)) % (1 << N);
            2: shd.acc = ((shd.acc & 'h00FFFF) | (b << 16)) % (1 << N);
            3: begin shd.coef = b % (1 << K); shd.fact = (b >> K) % (1 << L); end
            4: shd.dac = b % (1 << D);
            5: shd.dith = b % 8;
            6: begin shd.usb = b % 2; shd.chan = (b / 2) % 2; shd.ws = (b / 4) % 2; shd.ovr = (b / 8) % 2; end
            127: if (b % 2 == 1) act = shd;
            default: ;
        endcase
    endfunction

    function automatic int model_read(input int a);
        case (a)
            0: return act.acc % 256;
            1: return (act.acc / 256) % 256;
            2: return (act.acc / 65536) % 256;
            3: return act.fact * (1 << K) + act.coef;
            4: return act.dac;
            5: return act.dith;
            6: return act.ovr * 8 + act.ws * 4 + act.chan * 2 + act.usb;
            7: return ID;
            default: return 0;
        endcase
    endfunction

    task automatic check_outputs();
        check("acc_inc", acc_inc, act.acc);
        check("df_inc_coef", df_inc_coef, act.coef);
        check("df_inc_fact", df_inc_fact, act.fact);
        check("dac_ena", dac_ena, act.dac);
        check("dith_fact", dith_fact, (act.ovr == 0 && dith_disable_pin) ? 0 : act.dith);
        check("usb_i2sn", usb_i2sn, act.ovr != 0 ? act.usb : usb_i2sn_pin);
        check("audio_chan_sel", audio_chan_sel, act.ovr != 0 ? act.chan : audio_chan_sel_pin);
        check("i2s_ws_align", i2s_ws_align, act.ovr != 0 ? act.ws : i2s_ws_align_pin);
    endtask

    // All frame tasks start and end 1 time unit after a falling edge.
    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            rx[i] = spi_miso;
            @(negedge spi_clk); #1;
        end
    endtask

    task automatic bits(input int n);
        for (int i = 0; i < n; i++) begin
            spi_mosi = 1'($urandom);
            @(negedge spi_clk); #1;
        end
    endtask

    task automatic end_frame();
        spi_csn = 1'b1;
        spi_mosi = 1'b0;
        #1 check("idle_miso", spi_miso, 0);
        @(negedge spi_clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        spi_csn = 1'b1;
        @(negedge spi_clk); #1;
        rst = 1'b0;
        model_reset();
        check_outputs();
    endtask

    task automatic wr_burst(input logic [6:0] a, input int n);
        logic [7:0] rx;
        logic [6:0] p;
        p = a;
        spi_csn = 1'b0;
        xfer({1'b0, a}, rx);
        check("wr_cmd_miso", rx, 0);
        for (int i = 0; i < n; i++) begin
            xfer(wdat[i], rx);
            check("wr_miso", rx, 0);
            model_write(p, wdat[i]);
            p++;
        end
        end_frame();
        check_outputs();
    endtask

    task automatic rd_burst(input logic [6:0] a, input int n);
        logic [7:0] rx;
        logic [6:0] p;
        p = a;
        spi_csn = 1'b0;
        xfer({1'b1, a}, rx);
        check("rd_cmd_miso", rx, 0);
        for (int i = 0; i < n; i++) begin
            xfer(8'h00, rx);
            check("rd_data", rx, model_read(p));
            p++;
        end
        end_frame();
    endtask

    task automatic commit(input logic [7:0] b);
        wdat[0] = b;
        wr_burst(7'h7F, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] a;
        int op, pick, nb;
        rst = 1'b1; spi_csn = 1'b1; spi_mosi = 1'b0;
        usb_i2sn_pin = 1'b0; audio_chan_sel_pin = 1'b0; i2s_ws_align_pin = 1'b0; dith_disable_pin = 1'b0;
        #12;
        do_reset();
        check("rst_acc_inc", acc_inc, 65536);
        check("rst_dac_ena", dac_ena, 5'h1F);
        spi_csn = 1'b0;
        xfer(8'h80, r);
        for (int i = 0; i < 8; i++) begin
            xfer(8'h00, r);
            check("rst_readback", r, exp1[i]);
        end
        end_frame();

        wdat[0] = 8'h34; wdat[1] = 8'h12; wdat[2] = 8'h03;
        wr_burst(7'h00, 3);
        check("no_commit_acc", acc_inc, 65536);
        spi_csn = 1'b0;
        xfer(8'h7F, r);
        for (int i = 0; i < 7; i++) begin
            spi_mosi = 1'b0;
            @(negedge spi_clk); #1;
        end
        spi_mosi = 1'b1;
        check("pre_commit_acc", acc_inc, 65536);
        @(posedge spi_clk); #1;
        check("commit_edge_acc", acc_inc, 18'h31234);
        @(negedge spi_clk); #1;
        model_write(127, 1);
        end_frame();
        check_outputs();

        do_reset();
        wdat[0] = 8'($urandom); wdat[1] = 8'h00;
        wr_burst(7'h7E, 2);
        check("wrap_no_commit", acc_inc, 65536);
        rd_burst(7'h00, 1);

        do_reset();
        spi_csn = 1'b0;
        xfer(8'h04, r);
        bits(5);
        end_frame();
        commit(8'h01);
        check("partial_dac", dac_ena, 5'h1F);

        dith_disable_pin = 1'b1; usb_i2sn_pin = 1'b1; audio_chan_sel_pin = 1'b1; i2s_ws_align_pin = 1'b1;
        #1 check("dith_pin_off", dith_fact, 0);
        check_outputs();
        wdat[0] = 8'h08;
        wr_burst(7'h06, 1);
        commit(8'h01);
        check("ovr_dith", dith_fact, 2);
        check("ovr_flags", {usb_i2sn, audio_chan_sel, i2s_ws_align}, 3'b000);

        spi_csn = 1'b0;
        xfer(8'h80, r);
        xfer(8'h00, r);
        check("pre_rst_rd", r, model_read(0));
        bits(3);
        rst = 1'b1;
        #1 check("rst_miso", spi_miso, 0);
        model_reset();
        check_outputs();
        #1 rst = 1'b0;
        end_frame();
        rd_burst(7'h03, 5);

        for (int t = 0; t < 60; t++) begin
            op = $urandom_range(0, 4);
            pick = $urandom_range(0, 9);
            a = pick < 8 ? 7'(pick) : pick == 8 ? 7'h7E : 7'($urandom_range(8, 127));
            nb = $urandom_range(1, 4);
            if (op == 0) begin
                for (int i = 0; i < 4; i++) wdat[i] = 8'($urandom);
                wr_burst(a, nb);
            end else if (op == 1) rd_burst(a, nb);
            else if (op == 2) begin
                spi_csn = 1'b0;
                if ($urandom_range(0, 3) == 0) bits($urandom_range(1, 7));
                else begin
                    a = 7'($urandom_range(0, 6));
                    xfer({1'b0, a}, r);
                    for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
                        wdat[0] = 8'($urandom);
                        xfer(wdat[0], r);
                        model_write(a, wdat[0]);
                        a++;
                    end
                    bits($urandom_range(1, 7));
                end
                end_frame();
                check_outputs();
            end else if (op == 3) commit(8'($urandom));
            else begin
                {usb_i2sn_pin, audio_chan_sel_pin, i2s_ws_align_pin, dith_disable_pin} = 4'($urandom);
                #1 check_outputs();
            end
        end
        rd_burst(7'h00, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
